// File: rtl/task_10_in_if.sv
// rtl/task_10_in_if.sv - request-in and core-out byte stream bundle for task_10_in
interface task_10_in_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] i_tmanager_data;
    logic                  i_tmanager_valid;
    logic                  i_tmanager_last;
    logic                  o_tmanager_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_data_valid;
    logic                  o_data_last;
    logic                  i_core_ready;

    modport slave (
        input  i_tmanager_data,
        input  i_tmanager_valid,
        input  i_tmanager_last,
        output o_tmanager_ready,
        output o_data,
        output o_data_valid,
        output o_data_last,
        input  i_core_ready
    );

    modport master (
        output i_tmanager_data,
        output i_tmanager_valid,
        output i_tmanager_last,
        input  o_tmanager_ready,
        input  o_data,
        input  o_data_valid,
        input  o_data_last,
        output i_core_ready
    );
endinterface

// File: rtl/task_10_in.sv
// rtl/task_10_in.sv - buffers one request packet, then streams it to the task 10 core
module task_10_in #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    task_10_in_if.slave  bus,
    input  logic         i_downstream_busy,
    output logic [11:0]  o_packet_size_in_bytes,
    output logic         o_truncated,
    output logic         o_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN, FLUSH} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CNT_W-1:0]      occupancy;
    logic [CNT_W-1:0]      byte_cnt;
    logic                  full;
    logic                  empty;
    logic                  tm_ready;
    logic                  out_valid;
    logic                  accept;
    logic                  pop;

    assign full  = (occupancy == FULL_CNT);
    assign empty = (occupancy == '0);

    always_comb begin
        tm_ready = 1'b0;
        case (state)
            RECV:    tm_ready = !full;
            FLUSH:   tm_ready = 1'b1;
            default: tm_ready = 1'b0;
        endcase
    end

    assign out_valid = (state == DRAIN) && !empty;
    assign accept    = bus.i_tmanager_valid && tm_ready;
    assign pop       = out_valid && bus.i_core_ready;

    assign bus.o_tmanager_ready   = tm_ready;
    assign bus.o_data_valid       = out_valid;
    assign bus.o_data             = out_valid ? mem[rd_ptr] : '0;
    assign bus.o_data_last        = out_valid && (occupancy == ONE_CNT);
    assign o_packet_size_in_bytes = 12'(byte_cnt);
    assign o_busy                 = (state != IDLE);

    // Bytes accepted in FLUSH belong to the overflow tail and are never stored.
    always_ff @(posedge i_clk) begin
        if (accept && state == RECV) begin
            mem[wr_ptr] <= bus.i_tmanager_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            byte_cnt    <= '0;
            o_truncated <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_tmanager_valid && !i_downstream_busy) begin
                        state       <= RECV;
                        byte_cnt    <= '0;
                        o_truncated <= 1'b0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        wr_ptr    <= wr_ptr + AW'(1);
                        occupancy <= occupancy + ONE_CNT;
                        byte_cnt  <= byte_cnt + ONE_CNT;
                        // A marked last byte wins even when it exactly fills the FIFO.
                        if (bus.i_tmanager_last) begin
                            state <= DRAIN;
                        end else if (occupancy + ONE_CNT == FULL_CNT) begin
                            o_truncated <= 1'b1;
                            state       <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        rd_ptr    <= rd_ptr + AW'(1);
                        occupancy <= occupancy - ONE_CNT;
                        if (occupancy == ONE_CNT) begin
                            if (o_truncated) begin
                                state <= FLUSH;
                            end else begin
                                state    <= IDLE;
                                byte_cnt <= '0;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (accept && bus.i_tmanager_last) begin
                        state    <= IDLE;
                        byte_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_task_10_in.sv
// tb/tb_task_10_in.sv - scoreboard bench for task_10_in with randomized packets
module tb_task_10_in;
    localparam int DW    = 8;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        downstream_busy;
    logic [11:0] pkt_size;
    logic        truncated;
    logic        busy;

    always #5 clk = ~clk;

    task_10_in_if #(.DATA_WIDTH(DW)) bus ();

    task_10_in #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .bus                    (bus),
        .i_downstream_busy      (downstream_busy),
        .o_packet_size_in_bytes (pkt_size),
        .o_truncated            (truncated),
        .o_busy                 (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         size;
        logic       trunc;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    int         rdy_mode = 0;
    bit         busy_rand = 0;
    logic [7:0] pkt [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the first min(n, DEPTH) bytes come out, last on the final one.
    task automatic expect_pkt(input int n);
        int   m;
        exp_t e;
        m = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < m; i++) begin
            e.data  = pkt[i];
            e.last  = (i == m - 1);
            e.size  = m;
            e.trunc = (n > DEPTH);
            sb.push_back(e);
        end
    endtask

    task automatic send_pkt(input int n, input int n_send);
        int m;
        int t;
        m = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < n_send; i++) begin
            bus.i_tmanager_data  = pkt[i];
            bus.i_tmanager_valid = 1'b1;
            bus.i_tmanager_last  = (i == n - 1);
            t = 0;
            @(negedge clk);
            while (!bus.o_tmanager_ready && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (t >= 500) begin
                check("send_timeout", 32'(t), 32'(0));
                bus.i_tmanager_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (i == m - 1) begin
                bus.i_tmanager_valid = 1'b0;
                @(negedge clk);
                check("latency_valid", 32'(bus.o_data_valid), 32'(1));
                check("latency_data", 32'(bus.o_data), 32'(pkt[0]));
                check("latency_last", 32'(bus.o_data_last), 32'(m == 1));
            end
        end
        bus.i_tmanager_valid = 1'b0;
        bus.i_tmanager_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_in_time", 32'(t < 2000), 32'(1));
        check("leftover_expected", 32'(sb.size()), 32'(0));
        @(negedge clk);
        check("idle_size_zero", 32'(pkt_size), 32'(0));
    endtask

    initial begin
        bus.i_core_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.i_core_ready = 1'b1;
                1:       bus.i_core_ready = !bus.i_core_ready;
                default: bus.i_core_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (busy_rand) downstream_busy = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        exp_t       e;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("stall_hold_valid", 32'(bus.o_data_valid), 32'(1));
                    check("stall_hold_data", 32'(bus.o_data), 32'(pd));
                end
                if (!bus.o_data_valid) check("data_zero_when_invalid", 32'(bus.o_data), 32'(0));
                if (bus.o_data_valid && bus.i_core_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 32'(bus.o_data), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", 32'(bus.o_data), 32'(e.data));
                        check("out_last", 32'(bus.o_data_last), 32'(e.last));
                        if (e.last) begin
                            check("packet_size", 32'(pkt_size), 32'(e.size));
                            check("truncated", 32'(truncated), 32'(e.trunc));
                        end
                    end
                end
                pv = bus.o_data_valid;
                pr = bus.i_core_ready;
                pd = bus.o_data;
            end
        end
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n;
        rst                  = 1'b1;
        downstream_busy      = 1'b0;
        bus.i_tmanager_data  = '0;
        bus.i_tmanager_valid = 1'b0;
        bus.i_tmanager_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.o_tmanager_ready), 32'(0));
        check("rst_data", 32'(bus.o_data), 32'(0));
        check("rst_valid", 32'(bus.o_data_valid), 32'(0));
        check("rst_last", 32'(bus.o_data_last), 32'(0));
        check("rst_size", 32'(pkt_size), 32'(0));
        check("rst_trunc", 32'(truncated), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        rdy_mode = 0;
        for (int i = 0; i < 5; i++) pkt[i] = 8'h11 + 8'(i);
        expect_pkt(5);
        send_pkt(5, 5);
        wait_idle();

        rdy_mode = 1;
        for (int i = 0; i < 32; i++) pkt[i] = 8'($urandom);
        expect_pkt(32);
        send_pkt(32, 32);
        wait_idle();

        rdy_mode = 0;
        for (int i = 0; i < 40; i++) pkt[i] = 8'(i + 1);
        expect_pkt(40);
        send_pkt(40, 40);
        wait_idle();

        for (int i = 0; i < 4; i++) pkt[i] = 8'h60 + 8'(i);
        downstream_busy      = 1'b1;
        bus.i_tmanager_data  = pkt[0];
        bus.i_tmanager_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("held_off_ready", 32'(bus.o_tmanager_ready), 32'(0));
            check("held_off_busy", 32'(busy), 32'(0));
        end
        @(posedge clk);
        #1 downstream_busy = 1'b0;
        @(posedge clk);
        #1 check("recv_after_release", 32'(busy), 32'(1));
        expect_pkt(4);
        send_pkt(4, 4);
        wait_idle();

        pkt[0] = 8'hA5;
        expect_pkt(1);
        send_pkt(1, 1);
        wait_idle();

        for (int i = 0; i < 8; i++) pkt[i] = 8'hC0 + 8'(i);
        send_pkt(8, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(bus.o_tmanager_ready), 32'(0));
        check("midrst_valid", 32'(bus.o_data_valid), 32'(0));
        check("midrst_last", 32'(bus.o_data_last), 32'(0));
        check("midrst_size", 32'(pkt_size), 32'(0));
        check("midrst_trunc", 32'(truncated), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        repeat (5) begin
            @(negedge clk);
            check("midrst_no_output", 32'(bus.o_data_valid), 32'(0));
        end
        pkt[0] = 8'h3C;
        pkt[1] = 8'h4D;
        expect_pkt(2);
        send_pkt(2, 2);
        wait_idle();

        rdy_mode  = 2;
        busy_rand = 1'b1;
        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(1, 45);
            for (int i = 0; i < n; i++) pkt[i] = 8'($urandom);
            expect_pkt(n);
            send_pkt(n, n);
            wait_idle();
        end
        busy_rand = 1'b0;
        @(posedge clk);
        #1 downstream_busy = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
